// File: rtl/bp_pkg.sv
// Shared constants and counter helpers for the branch predictor.
package bp_pkg;

    localparam int ENTRIES_DEF = 32;
    localparam int CTR_W_DEF   = 2;
    localparam int GHR_W_DEF   = 5;

    // Counters are at most 4 bits wide, so helpers work on a 4-bit container.
    function automatic logic [3:0] ctr_init(input int w);
        return 4'((1 << (w - 1)) - 1);
    endfunction

    function automatic logic [3:0] ctr_next(
        input logic [3:0] ctr,
        input logic       taken,
        input int         w = CTR_W_DEF
    );
        logic [3:0] top;
        top = 4'((1 << w) - 1);
        if (taken && (ctr != top)) begin
            return ctr + 4'd1;
        end
        if (!taken && (ctr != 4'd0)) begin
            return ctr - 4'd1;
        end
        return ctr;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating direction counter with write enable.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= CTR_W'(ctr_init(CTR_W));
        end else if (we) begin
            ctr <= CTR_W'(ctr_next(4'(ctr), taken, CTR_W));
        end
    end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table: ENTRIES saturating counters, registered lookup.
// Define PHT_GSHARE_EN to XOR a global history register into the index.
module pattern_history_table
    import bp_pkg::*;
#(
    parameter  int ENTRIES = ENTRIES_DEF,
    parameter  int CTR_W   = CTR_W_DEF,
    parameter  int GHR_W   = GHR_W_DEF,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic             prediction,
    output logic             pred_valid,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    if (ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
        $error("ENTRIES must be a power of two, at least 2");
    end
    if (CTR_W < 1 || CTR_W > 4) begin : g_bad_ctr
        $error("CTR_W must be 1..4");
    end
    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
        $error("GHR_W must be 1..IDX_W");
    end

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic [CTR_W-1:0] rd_next;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        bp_sat_counter #(
            .CTR_W(CTR_W)
        ) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .we   (upd_en && (upd_idx == IDX_W'(i))),
            .taken(upd_taken),
            .ctr  (ctr_q[i])
        );
    end

`ifdef PHT_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    // Truncating {ghr, taken} keeps the newest GHR_W outcomes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_en) begin
            ghr <= GHR_W'({ghr, upd_taken});
        end
    end

    assign lk_idx = rd_addr ^ IDX_W'(ghr);
`else
    assign lk_idx = rd_addr;
`endif

    // Same-cycle update to the looked-up entry is forwarded.
    always_comb begin
        rd_ctr  = ctr_q[lk_idx];
        rd_next = rd_ctr;
        if (upd_en && (upd_idx == lk_idx)) begin
            rd_next = CTR_W'(ctr_next(4'(rd_ctr), upd_taken, CTR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prediction <= 1'b0;
            pred_valid <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= rd_en;
            if (rd_en) begin
                prediction <= rd_next[CTR_W-1];
                pred_idx   <= lk_idx;
            end
        end
    end

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed self-checking bench for pattern_history_table (default params).
module tb_pattern_history_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       prediction;
    logic       pred_valid;
    logic [4:0] pred_idx;
    logic       upd_en;
    logic [4:0] upd_idx;
    logic       upd_taken;

    int passed = 0;
    int total  = 0;

    pattern_history_table dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .prediction(prediction),
        .pred_valid(pred_valid),
        .pred_idx  (pred_idx),
        .upd_en    (upd_en),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rd_en = 1'b0; upd_en = 1'b0;
        rd_addr = '0; upd_idx = '0; upd_taken = 1'b0;
    endtask

    task automatic do_upd(input logic [4:0] idx, input logic tk);
        idle();
        upd_en = 1'b1; upd_idx = idx; upd_taken = tk;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [4:0] a);
        idle();
        rd_en = 1'b1; rd_addr = a;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({prediction, pred_valid, pred_idx} !== 7'd0)
            $display("FAIL reset_out got %b%b%0d want 000", prediction, pred_valid, pred_idx);
        else passed++;
        do_read(5'd5);
        total++;
        if (prediction !== 1'b0 || pred_valid !== 1'b1 || pred_idx !== 5'd5)
            $display("FAIL first_read got p=%b v=%b i=%0d want p=0 v=1 i=5", prediction, pred_valid, pred_idx);
        else passed++;
        tick();
        total++;
        if (pred_valid !== 1'b0 || pred_idx !== 5'd5)
            $display("FAIL idle_after_read got v=%b i=%0d want v=0 i=5", pred_valid, pred_idx);
        else passed++;
    endtask

    task automatic test_update();
        do_upd(5'd5, 1'b1);
        do_upd(5'd5, 1'b1);
        do_read(5'd5);
        total++;
        if (prediction !== 1'b1)
            $display("FAIL upd_11 got %b want 1", prediction);
        else passed++;
        tick();
        total++;
        if (prediction !== 1'b1 || pred_valid !== 1'b0)
            $display("FAIL hold got p=%b v=%b want p=1 v=0", prediction, pred_valid);
        else passed++;
        do_upd(5'd5, 1'b0);
        do_read(5'd5);
        total++;
        if (prediction !== 1'b1)
            $display("FAIL upd_10 got %b want 1", prediction);
        else passed++;
        do_upd(5'd5, 1'b0);
        do_read(5'd5);
        total++;
        if (prediction !== 1'b0)
            $display("FAIL upd_01 got %b want 0", prediction);
        else passed++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) do_upd(5'd7, 1'b1);
        do_upd(5'd7, 1'b0);
        do_read(5'd7);
        total++;
        if (prediction !== 1'b1 || pred_idx !== 5'd7)
            $display("FAIL sat_hi got p=%b i=%0d want p=1 i=7", prediction, pred_idx);
        else passed++;
        for (int i = 0; i < 4; i++) do_upd(5'd7, 1'b0);
        do_read(5'd7);
        total++;
        if (prediction !== 1'b0)
            $display("FAIL sat_lo got %b want 0", prediction);
        else passed++;
        do_upd(5'd7, 1'b1);
        do_read(5'd7);
        total++;
        if (prediction !== 1'b0)
            $display("FAIL sat_lo_01 got %b want 0", prediction);
        else passed++;
    endtask

    task automatic test_bypass();
        idle();
        rd_en = 1'b1; rd_addr = 5'd3;
        upd_en = 1'b1; upd_idx = 5'd3; upd_taken = 1'b1;
        tick();
        idle();
        total++;
        if (prediction !== 1'b1 || pred_valid !== 1'b1)
            $display("FAIL bypass got p=%b v=%b want p=1 v=1", prediction, pred_valid);
        else passed++;
        do_read(5'd3);
        total++;
        if (prediction !== 1'b1)
            $display("FAIL bypass_stored got %b want 1", prediction);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        idle();
        upd_en = 1'b1; upd_idx = 5'd10; upd_taken = 1'b1;
        tick();
        upd_idx = 5'd11; upd_taken = 1'b0;
        rd_en = 1'b1; rd_addr = 5'd12;
        tick();
        idle();
        total++;
        if (prediction !== 1'b0 || pred_idx !== 5'd12)
            $display("FAIL b2b_other got p=%b i=%0d want p=0 i=12", prediction, pred_idx);
        else passed++;
        do_read(5'd10);
        total++;
        if (prediction !== 1'b1)
            $display("FAIL b2b_idx10 got %b want 1", prediction);
        else passed++;
        do_read(5'd11);
        total++;
        if (prediction !== 1'b0)
            $display("FAIL b2b_idx11 got %b want 0", prediction);
        else passed++;
    endtask

    task automatic test_gshare();
        logic [4:0] exp_idx;
`ifdef PHT_GSHARE_EN
        exp_idx = 5'd2;
`else
        exp_idx = 5'd5;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) do_upd(5'd20, 1'b1);
        do_read(5'd5);
        total++;
        if (pred_idx !== exp_idx || prediction !== 1'b0)
            $display("FAIL gshare_idx got i=%0d p=%b want i=%0d p=0", pred_idx, prediction, exp_idx);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_upd(5'd9, 1'b1);
        do_read(5'd9);
        total++;
        if (prediction !== 1'b1)
            $display("FAIL pre_rst_idx9 got %b want 1", prediction);
        else passed++;
        idle();
        rst = 1'b1;
        rd_en = 1'b1; rd_addr = 5'd9;
        upd_en = 1'b1; upd_idx = 5'd9; upd_taken = 1'b1;
        tick();
        idle();
        total++;
        if ({prediction, pred_valid, pred_idx} !== 7'd0)
            $display("FAIL rst_mid_out got %b%b%0d want 000", prediction, pred_valid, pred_idx);
        else passed++;
        do_read(5'd9);
        total++;
        if (prediction !== 1'b0 || pred_idx !== 5'd9)
            $display("FAIL rst_mid_idx9 got p=%b i=%0d want p=0 i=9", prediction, pred_idx);
        else passed++;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        test_reset();
        test_update();
        test_saturate();
        test_bypass();
        test_back_to_back();
        test_gshare();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pattern_history_table.md
# pattern_history_table

Parametrised branch direction predictor that replaces the fixed 32-entry, 2-bit table in the fetch stage. It holds `ENTRIES` saturating counters of `CTR_W` bits and returns a registered taken/not-taken prediction for the fetch PC one cycle after the lookup. It is updated from the execute stage when a branch resolves. Optional gshare indexing XORs a global history register into the lookup index.

## Interface
- `ENTRIES`, 32: number of counters; a power of two, at least 2.
- `IDX_W`, `$clog2(ENTRIES)`: index width; derived, never overridden.
- `CTR_W`, 2: counter width, 1..4.
- `GHR_W`, 5: global history length, 1..`IDX_W`; used only with `PHT_GSHARE_EN`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: lookup request from fetch.
- `rd_addr` in `IDX_W`: lower PC bits of the fetch address (word-aligned).
- `prediction` out 1: registered predicted direction; 1 means taken.
- `pred_valid` out 1: high for one cycle after each accepted lookup.
- `pred_idx` out `IDX_W`: table index used by that lookup; the pipeline carries it to execute.
- `upd_en` in 1: resolved-branch update strobe.
- `upd_idx` in `IDX_W`: index to update (the `pred_idx` carried back from fetch).
- `upd_taken` in 1: resolved direction.

## Operation
- Counter state:
  - Reset value of every counter is weakly-not-taken, `2^(CTR_W-1)-1` (01 for `CTR_W`=2, 0 for `CTR_W`=1).
  - Predicted direction is the counter MSB.
- Update, on a clock edge with `upd_en`=1:
  - If `upd_taken`=1, increment the counter, saturating at all-ones.
  - If `upd_taken`=0, decrement the counter, saturating at zero.
  - There is no hysteresis shortcut: 01 goes to 10 on taken, and 10 goes to 01 on not-taken.
- Lookup, on a clock edge with `rd_en`=1:
  - Index = `rd_addr`, or `rd_addr ^ ghr` in gshare mode.
  - `pred_idx` <= index.
  - `prediction` <= MSB of the counter's next value.
  - `pred_valid` <= 1.
- With `rd_en`=0: `pred_valid` <= 0, while `prediction` and `pred_idx` hold their values.
- Read-during-write bypass: when `upd_en`=1, `rd_en`=1 and `upd_idx` equals the lookup index in the same cycle, `prediction` reflects the post-update counter value.
- Updates to different indices in consecutive cycles are independent; there is no back-pressure and every strobe is accepted.
- Reset:
  - `rst`=1 dominates `rd_en` and `upd_en`.
  - After the edge, all counters are at the reset value, `ghr`=0, `prediction`=0, `pred_valid`=0, `pred_idx`=0.
  - A reset asserted mid-stream discards any in-flight update.

## Timing
- Lookup latency is 1 cycle: `rd_addr` sampled at edge N appears on `prediction`/`pred_idx`/`pred_valid` after edge N.
- An update is visible to a lookup in the same cycle through the bypass, and to all later lookups.
- Outputs are driven directly from flops; the path from counter array to output is mux plus increment logic only.
- Throughput is one lookup and one update per cycle, simultaneously.

## Configuration
- `PHT_GSHARE_EN` defined:
  - A `GHR_W`-bit global history register `ghr` is instantiated, reset to 0.
  - On each `upd_en` edge, `ghr` <= {`ghr[GHR_W-2:0]`, `upd_taken`}; with `GHR_W`=1, `ghr` <= `upd_taken`.
  - The lookup index is `rd_addr ^ {zeros, ghr}`, with `ghr` XORed into the low bits.
  - A lookup in the same cycle as an update uses the pre-update `ghr`.
- `PHT_GSHARE_EN` undefined: no `ghr` flops exist, and the index equals `rd_addr`.

## Structure
- Package `bp_pkg` holds:
  - the counter reset-value function `ctr_init(CTR_W)`;
  - the saturating next-state function `ctr_next(ctr, taken)`;
  - the default parameter constants.
- Sub-module `bp_sat_counter` is one counter entry: register, synchronous reset to `ctr_init`, and write-enable. It is instantiated `ENTRIES` times via generate. The top level holds the index and bypass logic, the output registers and `ghr`.

## Test plan
Defaults (`ENTRIES`=32, `CTR_W`=2) apply unless stated.
- Reset, then `rd_en`=1, `rd_addr`=5 → next cycle `prediction`=0, `pred_valid`=1, `pred_idx`=5; the following idle cycle gives `pred_valid`=0.
- Two updates idx 5 taken (01→10→11), then read 5 → 1. One not-taken (→10), read → 1. Second not-taken (→01), read → 0.
- Five taken updates to idx 7 saturate at 11, then one not-taken → read 7 gives 1; four more not-taken saturate at 00 → read gives 0.
- Bypass: counter 3 at 01; same cycle `rd_addr`=3, `upd_idx`=3, `upd_taken`=1 → `prediction`=1 next cycle.
- `PHT_GSHARE_EN`, `GHR_W`=5: three taken updates (any idx) give `ghr`=00111; `rd_addr`=5 → `pred_idx`=2. Without the macro, the same stimulus gives `pred_idx`=5.
- `rst`=1 in a cycle with `rd_en`=1 and `upd_en`=1 at idx 9 → outputs 0. A subsequent read of idx 9 returns 0 (counter 01), and `ghr`=0.
